// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch stage: widths, reset defaults, the
// canonical NOP encoding and the fetch FSM state type.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FLUSH,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush, used for both the request PC
// tag queue and the prefetched instruction buffer. DEPTH must be a power of two.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves that same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests,
// buffers responses for decode and drops stale responses after a redirect.
// Optional misaligned-redirect trap enabled with `define FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);
    import riscv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [XLEN-1:0]     fetch_pc;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       drop_cnt;
    logic [CW-1:0]       drop_next;
    logic [CW-1:0]       ififo_count;
    logic [CW:0]         credit_used;
    logic                req_fire;
    logic                redirect_eff;
    logic                misaligned;
    logic                trap_hit;
    logic                rsp_drop;
    logic                rsp_push;
    logic                pop_instr;
    logic                tag_full;
    logic                tag_empty;
    logic                ififo_full;
    logic                ififo_empty;
    logic [XLEN-1:0]     tag_pc;
    logic [ILEN+XLEN-1:0] head;

    assign redirect_eff = redirect_valid && (state == S_FETCH || state == S_FLUSH);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned   = (redirect_pc[1:0] != 2'b00);
`else
    assign misaligned   = 1'b0;
`endif
    assign trap_hit     = redirect_eff && misaligned;

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign rsp_drop     = imem_rsp_valid && (redirect_eff || drop_cnt != '0 || state == S_HALT);
    assign rsp_push     = imem_rsp_valid && !rsp_drop;
    assign pop_instr    = instr_valid && instr_ready;
    assign credit_used  = {1'b0, inflight} + {1'b0, ififo_count};
    assign imem_req_addr = fetch_pc;

    // Every accepted request owns one tag entry until its response returns,
    // so the tag queue occupancy is exactly the number of requests in flight.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (fetch_pc),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .rdata (tag_pc),
        .count (inflight),
        .full  (tag_full),
        .empty (tag_empty)
    );

    fetch_fifo #(.WIDTH(ILEN + XLEN), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .wdata ({imem_rsp_data, tag_pc}),
        .pop   (pop_instr),
        .flush (redirect_eff),
        .rdata (head),
        .count (ififo_count),
        .full  (ififo_full),
        .empty (ififo_empty)
    );

    always_comb begin
        drop_next = drop_cnt;
        if (redirect_eff) begin
            drop_next = inflight - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && drop_cnt != '0) begin
            drop_next = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_BOOT;
            drop_cnt <= '0;
            fetch_pc <= XLEN'(RESET_PC);
        end else begin
            state    <= state_next;
            drop_cnt <= drop_next;
            if (redirect_eff) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT: state_next = S_FETCH;
            S_FETCH, S_FLUSH: begin
                if (redirect_eff) begin
                    if (trap_hit) begin
                        state_next = S_HALT;
                    end else if (drop_next != '0) begin
                        state_next = S_FLUSH;
                    end else begin
                        state_next = S_FETCH;
                    end
                end else if (state == S_FLUSH && drop_next == '0) begin
                    state_next = S_FETCH;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_FETCH) && !redirect_valid
                         && (credit_used < (CW+1)'(FIFO_DEPTH));
        instr_valid    = !ififo_empty && !redirect_eff && (state != S_HALT);
        instr          = NOP_INSTR;
        instr_pc       = '0;
        if (instr_valid) begin
            instr    = head[ILEN+XLEN-1:XLEN];
            instr_pc = head[XLEN-1:0];
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (trap_hit) begin
            fetch_fault <= 1'b1;
        end
    end
`endif

    // The credit check should make these impossible with a well-behaved memory.
    assert property (@(posedge clk) disable iff (rst) rsp_push |-> !ififo_full);
    assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> !tag_empty);
    assert property (@(posedge clk) disable iff (rst) req_fire |-> !tag_full);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit with an in-order memory
// model and a queue-based fetch reference model (FETCH_MISALIGN_TRAP_EN aware).
module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_instr_t;

    mem_req_t    mem_q[$];
    logic [31:0] tag_q[$];
    exp_instr_t  exp_q[$];
    logic [31:0] model_pc;
    int          drop;
    bit          halted;
    int          cyc;
    int          last_due;
    int          n_cmp;
    int          n_bad;
    int          p_ready;
    int          p_dec;
    int          p_redir;
    int          max_lat;
    bit          force_redir;
    logic [31:0] force_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_instr_valid", instr_valid, 0);
        checkOutput("rst_instr", instr, NOP);
        checkOutput("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("rst_fetch_fault", fetch_fault, 0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("boot_req_valid", imem_req_valid, 0);
        mem_q.delete();
        tag_q.delete();
        exp_q.delete();
        model_pc = 32'h0000_0000;
        drop     = 0;
        halted   = 1'b0;
        last_due = cyc;
    endtask

    // One clock cycle: drive memory/decode/redirect inputs, compare against the model, advance it.
    task automatic applyStimulus();
        bit          rsp;
        bit          redir;
        bit          exp_req;
        bit          exp_iv;
        logic [31:0] rpc;
        logic [31:0] tpc;
        mem_req_t    m;
        int          due;

        @(negedge clk);
        cyc++;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_of(mem_q[0].addr) : $urandom;
        imem_req_ready = ($urandom_range(99) < p_ready);
        instr_ready    = ($urandom_range(99) < p_dec);
        redir = force_redir || (!halted && ($urandom_range(99) < p_redir));
        case ($urandom_range(3))
            0:       rpc = 32'h0000_0100;
            1:       rpc = 32'hFFFF_FFF4;
            2:       rpc = 32'hFFFF_FFFC;
            default: rpc = $urandom;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        rpc = rpc & 32'hFFFF_FFFC;
`endif
        if (force_redir) rpc = force_pc;
        redirect_valid = redir;
        redirect_pc    = rpc;
        force_redir    = 1'b0;
        #1;

        exp_req = !halted && (drop == 0) && !redir && (tag_q.size() + exp_q.size() < DEPTH);
        exp_iv  = !halted && (exp_q.size() > 0) && !redir;
        checkOutput("req_valid", imem_req_valid, exp_req);
        if (exp_req && imem_req_valid) checkOutput("req_addr", imem_req_addr, model_pc);
        checkOutput("instr_valid", instr_valid, exp_iv);
        if (exp_iv && instr_valid) begin
            checkOutput("instr", instr, exp_q[0].data);
            checkOutput("instr_pc", instr_pc, exp_q[0].pc);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("fetch_fault", fetch_fault, halted);
`endif

        if (rsp) begin
            m = mem_q.pop_front();
            tpc = (tag_q.size() > 0) ? tag_q.pop_front() : 32'hDEAD_BEEF;
            if (!(redir || halted)) begin
                if (drop > 0) drop--;
                else exp_q.push_back('{pc: tpc, data: word_of(tpc)});
            end
        end
        if (redir) begin
            exp_q.delete();
            drop = tag_q.size();
            model_pc = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) halted = 1'b1;
`endif
        end else if (exp_iv && instr_ready) begin
            void'(exp_q.pop_front());
        end
        if (exp_req && imem_req_ready) begin
            tag_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + $urandom_range(max_lat, 1);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due});
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        cyc         = 0;
        force_redir = 1'b0;
        force_pc    = '0;
        applyReset();

        // Streaming with a fast memory and an always-ready decoder.
        p_ready = 100; p_dec = 100; p_redir = 0; max_lat = 1;
        runCycles(30);

        // Decoder stall fills the buffer, then drains in order.
        p_dec = 0;
        runCycles(10);
        p_dec = 100;
        runCycles(10);

        // Slow memory, redirect with requests in flight.
        max_lat = 3;
        runCycles(6);
        force_redir = 1'b1; force_pc = 32'h0000_0100;
        runCycles(20);

        // Fetch PC wraps from the top of the address space.
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        runCycles(12);

        for (int ph = 0; ph < 4; ph++) begin
            p_ready = 40 + 20 * ph;
            p_dec   = 90 - 25 * ph;
            p_redir = 3 + 2 * ph;
            max_lat = 1 + ph;
            runCycles(500);
        end

        // Misaligned redirect target.
        p_ready = 100; p_dec = 100; p_redir = 0; max_lat = 2;
        runCycles(5);
        force_redir = 1'b1; force_pc = 32'h0000_0102;
        runCycles(20);

        applyReset();
        p_redir = 5;
        runCycles(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
